// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/return plus the decode-side
// instruction hand-off and redirect inputs. The fetch unit uses the master modport.
interface instruction_fetch_unit_if #(
  parameter int N = 3,
  parameter int M = 15,
  parameter int L = 11,
  parameter int P = 11
);
  // Instruction memory: a request is accepted whenever imem_rd_en is high;
  // imem_data carries the word one cycle later.
  logic             imem_rd_en;
  logic [P:0]       imem_addr;
  logic [N+M+1:0]   imem_data;

  // Decode hand-off: valid/ready -- the held instruction transfers on a cycle
  // where inst_valid and dec_ready are both high, and stays stable while
  // inst_valid is high and dec_ready is low.
  logic [N:0]       opc;
  logic [M:0]       inst_left;
  logic             inst_valid;
  logic [P:0]       inst_pc;
  logic             dec_ready;

  logic             jump_imm_sel;
  logic             branch_taken;
  logic [L:0]       jump_imm;
  logic [P:0]       branch_pc;

  modport master (
    output imem_rd_en, imem_addr,
    input  imem_data,
    output opc, inst_left, inst_valid, inst_pc,
    input  dec_ready,
    input  jump_imm_sel, branch_taken, jump_imm, branch_pc
  );

  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_data,
    input  opc, inst_left, inst_valid, inst_pc,
    output dec_ready,
    output jump_imm_sel, branch_taken, jump_imm, branch_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues single-cycle-latency memory reads,
// presents opc/inst_left to decode and applies jump/branch redirects.
module instruction_fetch_unit #(
  parameter int N = 3,
  parameter int M = 15,
  parameter int L = 11,
  parameter int P = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  bus,
  output logic                      dbg_state_o,
  output logic                      dbg_skid_valid_o
);

  if (L != P) begin : g_param_check
    $error("instruction_fetch_unit: jump_imm width must equal PC width");
  end

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e          state_q;
  logic [P:0]      pc_q;
  logic [P:0]      pc_d;
  logic            pending_q;
  logic [P:0]      pend_pc_q;
  logic            skid_valid_q;
  logic [N+M+1:0]  skid_q;
  logic [P:0]      skid_pc_q;
  logic            inst_valid_q;
  logic [N:0]      opc_q;
  logic [M:0]      inst_left_q;
  logic [P:0]      inst_pc_q;

  logic            redirect;
  logic [P:0]      target;
  logic            hold;
  logic            rd_en;

  always_comb begin
    redirect = bus.jump_imm_sel | bus.branch_taken;
    target   = bus.jump_imm_sel ? bus.jump_imm : (bus.branch_pc + bus.jump_imm);
    hold     = inst_valid_q & ~bus.dec_ready;
    // At most one read is ever in flight: a held instruction blocks new requests,
    // so the skid buffer only ever has to absorb the single returning word.
    rd_en    = ~rst & (state_q == ST_RUN) & ~redirect & ~hold;
    pc_d     = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= '0;
      pending_q    <= 1'b0;
      pend_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      opc_q        <= '0;
      inst_left_q  <= '0;
      inst_pc_q    <= '0;
    end else if (redirect) begin
      // Whatever is returning or buffered belongs to the old path.
      pc_q         <= target;
      pending_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      inst_valid_q <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      pending_q <= rd_en;
      if (rd_en) begin
        pc_q      <= pc_d;
        pend_pc_q <= pc_q;
      end
      case (state_q)
        ST_STALL: begin
          if (bus.dec_ready) begin
            opc_q        <= skid_q[N+M+1:M+1];
            inst_left_q  <= skid_q[M:0];
            inst_pc_q    <= skid_pc_q;
            inst_valid_q <= 1'b1;
            skid_valid_q <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
        default: begin
          if (pending_q) begin
            if (!hold) begin
              opc_q        <= bus.imem_data[N+M+1:M+1];
              inst_left_q  <= bus.imem_data[M:0];
              inst_pc_q    <= pend_pc_q;
              inst_valid_q <= 1'b1;
            end else begin
              skid_q       <= bus.imem_data;
              skid_pc_q    <= pend_pc_q;
              skid_valid_q <= 1'b1;
              state_q      <= ST_STALL;
            end
          end else if (inst_valid_q && bus.dec_ready) begin
            inst_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.imem_rd_en = rd_en;
  assign bus.imem_addr  = pc_q;
  assign bus.opc        = opc_q;
  assign bus.inst_left  = inst_left_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_pc    = inst_pc_q;

  assign dbg_state_o      = state_q;
  assign dbg_skid_valid_o = skid_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed cycle table, a reset-while-pending
// sequence, and a random run checked against an instruction-stream model.
module tb_instruction_fetch_unit;

  localparam int N = 3;
  localparam int M = 15;
  localparam int L = 11;
  localparam int P = 11;
  localparam int W = N + M + 2;

  logic clk;
  logic rst;
  logic dbg_state;
  logic dbg_skid_valid;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] mem [0:(1<<(P+1))-1];

  instruction_fetch_unit_if #(.N(N), .M(M), .L(L), .P(P)) bus ();

  instruction_fetch_unit #(.N(N), .M(M), .L(L), .P(P)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .dbg_state_o      (dbg_state),
    .dbg_skid_valid_o (dbg_skid_valid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model (1-cycle read latency) ----------------
  function automatic logic [W-1:0] word_of(input logic [P:0] a);
    return {a[3:0] ^ 4'h5, ~a[11:8], a};
  endfunction

  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_data <= mem[bus.imem_addr];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input string name, input logic [P:0] a);
    logic [W-1:0] w;
    w = word_of(a);
    check({name, "_opc"}, 32'(bus.opc), 32'(w[N+M+1:M+1]));
    check({name, "_left"}, 32'(bus.inst_left), 32'(w[M:0]));
  endtask

  task automatic drive(input logic r, input logic dr, input logic js, input logic bt,
                       input logic [L:0] imm, input logic [P:0] bpc);
    rst              = r;
    bus.dec_ready    = dr;
    bus.jump_imm_sel = js;
    bus.branch_taken = bt;
    bus.jump_imm     = imm;
    bus.branch_pc    = bpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst;
    logic       dr;
    logic       js;
    logic       bt;
    logic [L:0] imm;
    logic [P:0] bpc;
    logic       exp_rd;
    logic [P:0] exp_addr;
    logic       exp_iv;
    logic [P:0] exp_ipc;
    logic       exp_stall;
    logic       exp_zero;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic dr, input logic js, input logic bt,
                              input logic [L:0] imm, input logic [P:0] bpc,
                              input logic rd, input logic [P:0] addr, input logic iv,
                              input logic [P:0] ipc, input logic st, input logic z);
    vec_t v;
    v.rst = r; v.dr = dr; v.js = js; v.bt = bt; v.imm = imm; v.bpc = bpc;
    v.exp_rd = rd; v.exp_addr = addr; v.exp_iv = iv; v.exp_ipc = ipc;
    v.exp_stall = st; v.exp_zero = z;
    return v;
  endfunction

  // ---------------- random-phase stream model ----------------
  logic [P:0] exp_pc;
  int         gap;
  int         consumed;

  initial begin
    logic [L:0] imm;
    logic [P:0] bpc;
    logic       js, bt, dr;
    int         sel;

    for (int i = 0; i < (1 << (P+1)); i++) mem[i] = word_of(12'(i));
    bus.imem_data = '0;

    // Row = one cycle: inputs driven, then outputs expected during that cycle.
    tbl[0]  = mk(0,1,0,0,12'h000,12'h000, 1,12'h000,0,12'h000,0,1);
    tbl[1]  = mk(0,1,0,0,12'h000,12'h000, 1,12'h001,0,12'h000,0,1);
    tbl[2]  = mk(0,1,0,0,12'h000,12'h000, 1,12'h002,1,12'h000,0,0);
    tbl[3]  = mk(0,0,0,0,12'h000,12'h000, 0,12'h003,1,12'h001,0,0);
    tbl[4]  = mk(0,0,0,0,12'h000,12'h000, 0,12'h003,1,12'h001,1,0);
    tbl[5]  = mk(0,0,0,0,12'h000,12'h000, 0,12'h003,1,12'h001,1,0);
    tbl[6]  = mk(0,1,0,0,12'h000,12'h000, 0,12'h003,1,12'h001,1,0);
    tbl[7]  = mk(0,1,0,0,12'h000,12'h000, 1,12'h003,1,12'h002,0,0);
    tbl[8]  = mk(0,1,0,0,12'h000,12'h000, 1,12'h004,0,12'h002,0,0);
    tbl[9]  = mk(0,1,0,0,12'h000,12'h000, 1,12'h005,1,12'h003,0,0);
    tbl[10] = mk(0,1,1,0,12'h040,12'h000, 0,12'h006,1,12'h004,0,0);
    tbl[11] = mk(0,1,0,0,12'h000,12'h000, 1,12'h040,0,12'h004,0,0);
    tbl[12] = mk(0,1,0,0,12'h000,12'h000, 1,12'h041,0,12'h004,0,0);
    tbl[13] = mk(0,1,0,1,12'hFFC,12'h010, 0,12'h042,1,12'h040,0,0);
    tbl[14] = mk(0,1,1,1,12'h7F0,12'h100, 0,12'h00C,0,12'h040,0,0);
    tbl[15] = mk(0,1,0,0,12'h000,12'h000, 1,12'h7F0,0,12'h040,0,0);
    tbl[16] = mk(0,1,0,0,12'h000,12'h000, 1,12'h7F1,0,12'h040,0,0);
    tbl[17] = mk(0,1,1,0,12'hFFE,12'h000, 0,12'h7F2,1,12'h7F0,0,0);
    tbl[18] = mk(0,1,0,0,12'h000,12'h000, 1,12'hFFE,0,12'h7F0,0,0);
    tbl[19] = mk(0,1,0,0,12'h000,12'h000, 1,12'hFFF,0,12'h7F0,0,0);
    tbl[20] = mk(0,1,0,0,12'h000,12'h000, 1,12'h000,1,12'hFFE,0,0);
    tbl[21] = mk(0,1,0,0,12'h000,12'h000, 1,12'h001,1,12'hFFF,0,0);
    tbl[22] = mk(0,0,0,0,12'h000,12'h000, 0,12'h002,1,12'h000,0,0);
    tbl[23] = mk(1,0,0,0,12'h000,12'h000, 0,12'h002,1,12'h000,1,0);
    tbl[24] = mk(0,0,0,0,12'h000,12'h000, 1,12'h000,0,12'h000,0,1);
    tbl[25] = mk(0,0,0,0,12'h000,12'h000, 1,12'h001,0,12'h000,0,1);
    tbl[26] = mk(0,0,0,0,12'h000,12'h000, 0,12'h002,1,12'h000,0,0);
    tbl[27] = mk(0,1,0,0,12'h000,12'h000, 0,12'h002,1,12'h000,1,0);
    tbl[28] = mk(0,1,0,0,12'h000,12'h000, 1,12'h002,1,12'h001,0,0);

    drive(1, 0, 0, 0, '0, '0);
    repeat (2) next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].dr, tbl[i].js, tbl[i].bt, tbl[i].imm, tbl[i].bpc);
      @(negedge clk);
      check($sformatf("row%0d_rd_en", i), 32'(bus.imem_rd_en), 32'(tbl[i].exp_rd));
      check($sformatf("row%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].exp_addr));
      check($sformatf("row%0d_valid", i), 32'(bus.inst_valid), 32'(tbl[i].exp_iv));
      check($sformatf("row%0d_inst_pc", i), 32'(bus.inst_pc), 32'(tbl[i].exp_ipc));
      check($sformatf("row%0d_stall", i), 32'(dbg_state), 32'(tbl[i].exp_stall));
      if (tbl[i].exp_iv) begin
        check_data($sformatf("row%0d", i), tbl[i].exp_ipc);
      end else if (tbl[i].exp_zero) begin
        check($sformatf("row%0d_opc_zero", i), 32'(bus.opc), 32'd0);
        check($sformatf("row%0d_left_zero", i), 32'(bus.inst_left), 32'd0);
      end
      next_cycle();
    end

    // Reset while a read is in flight: the returning word must be ignored.
    drive(1, 1, 0, 0, '0, '0);
    @(negedge clk);
    check("rst_pending_rd_en", 32'(bus.imem_rd_en), 32'd0);
    next_cycle();
    drive(0, 1, 0, 0, '0, '0);
    @(negedge clk);
    check("rst_pending_valid0", 32'(bus.inst_valid), 32'd0);
    check("rst_pending_addr0", 32'(bus.imem_addr), 32'd0);
    check("rst_pending_rd0", 32'(bus.imem_rd_en), 32'd1);
    check("rst_pending_opc0", 32'(bus.opc), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rst_pending_valid1", 32'(bus.inst_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rst_pending_valid2", 32'(bus.inst_valid), 32'd1);
    check("rst_pending_ipc2", 32'(bus.inst_pc), 32'd0);
    check_data("rst_pending", 12'h000);
    next_cycle();

    // Random run: every instruction decode accepts must be the next one on the
    // program path, and decode must not wait long while it is ready.
    drive(1, 0, 0, 0, '0, '0);
    repeat (2) next_cycle();
    exp_pc   = '0;
    gap      = 0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      dr  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      js  = (sel == 0) || (sel == 2);
      bt  = (sel == 1) || (sel == 2);
      imm = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7)) : 12'($urandom);
      bpc = 12'($urandom);
      drive(0, dr, js, bt, imm, bpc);
      @(negedge clk);
      if (bus.inst_valid && dr) begin
        check("rand_inst_pc", 32'(bus.inst_pc), 32'(exp_pc));
        check_data("rand", exp_pc);
        exp_pc = exp_pc + 1'b1;
        gap    = 0;
        consumed++;
      end
      if (js) begin
        exp_pc = imm;
        gap    = 0;
      end else if (bt) begin
        exp_pc = bpc + imm;
        gap    = 0;
      end else if (dr && !bus.inst_valid) begin
        gap++;
        check("rand_throughput_gap", 32'(gap > 2), 32'd0);
      end
      next_cycle();
    end
    check("rand_progress", 32'(consumed > 1000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
